// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation codes, FSM states,
// and small elaboration-time helpers used by both the top and the datapath.
package shifter_pkg;

   typedef enum logic [2:0] {
      MODE_LSL = 3'b000,
      MODE_LSR = 3'b001,
      MODE_ASR = 3'b010,
      MODE_ROL = 3'b011,
      MODE_ROR = 3'b100
   } shift_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } shift_state_e;

   // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic logic isLegalMode(input logic [2:0] mode);
      return (mode <= 3'd4);
   endfunction

   function automatic logic isRotateMode(input logic [2:0] mode);
      return (mode == MODE_ROL) || (mode == MODE_ROR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step datapath: shifts or rotates WIDTH bits by k
// positions in the selected mode; k may be anything from 0 to WIDTH.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int K_W   = 4
) (
   input  logic [WIDTH-1:0] i_data,
   input  shift_mode_e      i_mode,
   input  logic [K_W-1:0]   i_k,
   output logic [WIDTH-1:0] o_data
);

   // Rotates combine both directions; a zero step shifts the wrap half out by WIDTH.
   always_comb begin
      o_data = i_data;
      case (i_mode)
         MODE_LSL: o_data = i_data << i_k;
         MODE_LSR: o_data = i_data >> i_k;
         MODE_ASR: o_data = $unsigned($signed(i_data) >>> i_k);
         MODE_ROL: o_data = (i_data << i_k) | (i_data >> (WIDTH - int'(i_k)));
         MODE_ROR: o_data = (i_data >> i_k) | (i_data << (WIDTH - int'(i_k)));
         default:  o_data = i_data;
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: captures an operand on start, then moves it
// up to STEP bit positions per clock until the requested count is consumed.
module seq_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int AMT_W = clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // Counter only ever holds 0..WIDTH, independent of how wide the amount port is.
   localparam int CNT_W = clog2(WIDTH + 1);

   shift_state_e     r_state;
   shift_state_e     w_nextState;
   shift_mode_e      r_mode;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_stepped;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_effCount;
   logic [CNT_W-1:0] w_k;
   logic             r_err;
   logic             w_legal;

   // Rotations wrap the count modulo WIDTH; plain shifts saturate at WIDTH.
   always_comb begin
      w_legal    = isLegalMode(mode);
      w_effCount = '0;
      if (w_legal) begin
         if (isRotateMode(mode))
            w_effCount = CNT_W'(int'(amount) % WIDTH);
         else if (int'(amount) > WIDTH)
            w_effCount = CNT_W'(WIDTH);
         else
            w_effCount = CNT_W'(amount);
      end
   end

   assign w_k = (r_remaining > CNT_W'(STEP)) ? CNT_W'(STEP) : r_remaining;

   shift_step #(
      .WIDTH (WIDTH),
      .K_W   (CNT_W)
   ) u_step (
      .i_data (r_work),
      .i_mode (r_mode),
      .i_k    (w_k),
      .o_data (w_stepped)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nextState;
   end

   // Illegal modes carry a zero count, so they fall straight through to DONE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start)
               w_nextState = (w_effCount != '0) ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            if (r_remaining <= CNT_W'(STEP))
               w_nextState = ST_DONE;
         end
         ST_DONE: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work      <= '0;
         r_remaining <= '0;
         r_err       <= 1'b0;
         r_mode      <= MODE_LSL;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_work      <= data_in;
                  r_mode      <= w_legal ? shift_mode_e'(mode) : MODE_LSL;
                  r_remaining <= w_effCount;
                  r_err       <= ~w_legal;
               end
            end
            ST_SHIFT: begin
               r_work      <= w_stepped;
               r_remaining <= r_remaining - w_k;
            end
            default: ;
         endcase
      end
   end

   assign ready  = (r_state == ST_IDLE);
   assign busy   = (r_state == ST_SHIFT);
   assign done   = (r_state == ST_DONE);
   assign result = r_work;
   assign err    = r_err;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed corner cases plus random
// operations compared against a bit-level behavioural model.
module tb_seq_shifter;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       start = 1'b0;
   logic [7:0] data_in = '0;
   logic [2:0] mode = '0;
   logic [3:0] amount = '0;
   logic       ready, busy, done, err;
   logic [7:0] result;

   logic       startB = 1'b0;
   logic [7:0] dataB = '0;
   logic [2:0] modeB = '0;
   logic [3:0] amountB = '0;
   logic       readyB, busyB, doneB, errB;
   logic [7:0] resultB;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_shifter #(.WIDTH(8), .STEP(1), .AMT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .mode(mode),
      .amount(amount), .ready(ready), .busy(busy), .done(done),
      .result(result), .err(err)
   );

   seq_shifter #(.WIDTH(8), .STEP(4), .AMT_W(4)) dutB (
      .clk(clk), .rst(rst), .start(startB), .data_in(dataB), .mode(modeB),
      .amount(amountB), .ready(readyB), .busy(busyB), .done(doneB),
      .result(resultB), .err(errB)
   );

   // Reference: each result bit is picked from its source bit position.
   function automatic void refModel(input logic [7:0] d, input logic [2:0] m,
                                    input int a, input int step,
                                    output logic [7:0] r, output logic e,
                                    output int edges);
      int n;
      r = d;
      e = 1'b0;
      edges = 0;
      if (m > 3'd4) begin
         e = 1'b1;
         return;
      end
      if (m == 3'd3 || m == 3'd4) n = a % W;
      else n = (a > W) ? W : a;
      for (int i = 0; i < W; i++) begin
         case (m)
            3'd0:    r[i] = (i >= n) ? d[i-n] : 1'b0;
            3'd1:    r[i] = (i + n < W) ? d[i+n] : 1'b0;
            3'd2:    r[i] = (i + n < W) ? d[i+n] : d[W-1];
            3'd3:    r[i] = d[(i - n + W) % W];
            default: r[i] = d[(i + n) % W];
         endcase
      end
      edges = (n + step - 1) / step;
   endfunction

   // Runs one operation on the STEP=1 instance; entered and left at posedge+1 in IDLE.
   task automatic runOp(input string name, input logic [7:0] d, input logic [2:0] m,
                        input logic [3:0] a, output logic [7:0] obsResult,
                        output int obsEdges);
      logic [7:0] expRes;
      logic       expErr;
      int         expEdges;
      refModel(d, m, int'(a), 1, expRes, expErr, expEdges);
      data_in = d; mode = m; amount = a; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      data_in = 8'($urandom); mode = 3'($urandom); amount = 4'($urandom);
      obsEdges = 0;
      @(negedge clk);
      while (done !== 1'b1 && obsEdges < 40) begin
         checks++;
         if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_busy: got busy=%b ready=%b expected busy=1 ready=0", name, busy, ready);
         end
         @(posedge clk); obsEdges++;
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s_timeout: got done=%b expected done=1 within 40 cycles", name, done);
      end
      checks++;
      if (result !== expRes) begin
         failures++;
         $display("[TB] FAIL %s_result: got %h expected %h", name, result, expRes);
      end
      checks++;
      if (err !== expErr) begin
         failures++;
         $display("[TB] FAIL %s_err: got %b expected %b", name, err, expErr);
      end
      checks++;
      if (obsEdges !== expEdges) begin
         failures++;
         $display("[TB] FAIL %s_latency: got %0d shift cycles expected %0d", name, obsEdges, expEdges);
      end
      obsResult = result;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || result !== expRes || err !== expErr) begin
         failures++;
         $display("[TB] FAIL %s_after_done: got done=%b ready=%b result=%h err=%b expected 0 1 %h %b",
                  name, done, ready, result, err, expRes, expErr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got ready=%b busy=%b done=%b err=%b expected 1 0 0 0", ready, busy, done, err);
      end
      checks++;
      if (result !== 8'h00 || resultB !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_result: got %h/%h expected 00/00", result, resultB);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_lsl();
      logic [7:0] r; int e;
      runOp("lsl", 8'h0B, 3'b000, 4'd3, r, e);
      checks++;
      if (r !== 8'h58 || e !== 3) begin
         failures++;
         $display("[TB] FAIL lsl_directed: got %h/%0d expected 58/3", r, e);
      end
   endtask

   task automatic test_asr_rotate();
      logic [7:0] r; int e;
      runOp("asr", 8'h90, 3'b010, 4'd2, r, e);
      checks++;
      if (r !== 8'hE4) begin failures++; $display("[TB] FAIL asr_directed: got %h expected e4", r); end
      runOp("ror", 8'h81, 3'b100, 4'd1, r, e);
      checks++;
      if (r !== 8'hC0) begin failures++; $display("[TB] FAIL ror_directed: got %h expected c0", r); end
      runOp("rol", 8'h81, 3'b011, 4'd10, r, e);
      checks++;
      if (r !== 8'h06 || e !== 2) begin
         failures++;
         $display("[TB] FAIL rol_directed: got %h/%0d expected 06/2", r, e);
      end
   endtask

   task automatic test_clamp_zero();
      logic [7:0] r; int e;
      runOp("lsr_clamp", 8'hFF, 3'b001, 4'd12, r, e);
      checks++;
      if (r !== 8'h00 || e !== 8) begin
         failures++;
         $display("[TB] FAIL lsr_clamp: got %h/%0d expected 00/8", r, e);
      end
      for (int m = 0; m < 5; m++) begin
         runOp("zero_count", 8'h5A, 3'(m), 4'd0, r, e);
         checks++;
         if (r !== 8'h5A || e !== 0) begin
            failures++;
            $display("[TB] FAIL zero_count: mode %0d got %h/%0d expected 5a/0", m, r, e);
         end
      end
   endtask

   task automatic test_illegal();
      logic [7:0] r; int e;
      runOp("illegal", 8'hC3, 3'b110, 4'd5, r, e);
      checks++;
      if (r !== 8'hC3 || err !== 1'b1 || e !== 0) begin
         failures++;
         $display("[TB] FAIL illegal_mode: got %h err=%b lat=%0d expected c3 err=1 lat=0", r, err, e);
      end
   endtask

   task automatic test_ignored_start();
      int edges;
      data_in = 8'h0B; mode = 3'b000; amount = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      data_in = 8'hFF; mode = 3'b011; amount = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      @(negedge clk);
      while (done !== 1'b1 && edges < 40) begin
         @(posedge clk); edges++;
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || result !== 8'h58 || err !== 1'b0 || edges !== 3) begin
         failures++;
         $display("[TB] FAIL ignored_start: got done=%b result=%h err=%b lat=%0d expected 1 58 0 3",
                  done, result, err, edges);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      logic [7:0] r; int e;
      logic sawDone;
      data_in = 8'hA5; mode = 3'b001; amount = 4'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_state: got ready=%b busy=%b done=%b result=%h err=%b expected 1 0 0 00 0",
                  ready, busy, done, result, err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done !== 1'b0) sawDone = 1'b1;
      end
      checks++;
      if (sawDone) begin failures++; $display("[TB] FAIL abort_no_done: got done pulse expected none"); end
      @(posedge clk); #1;
      runOp("after_abort", 8'h3C, 3'b011, 4'd2, r, e);
      checks++;
      if (r !== 8'hF0) begin failures++; $display("[TB] FAIL after_abort: got %h expected f0", r); end
   endtask

   task automatic test_random();
      logic [7:0] r; int e;
      for (int i = 0; i < 40; i++)
         runOp("random", 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), r, e);
   endtask

   task automatic test_back_to_back();
      logic [7:0] r; int e;
      runOp("b2b_first", 8'h96, 3'b100, 4'd3, r, e);
      runOp("b2b_second", 8'h96, 3'b010, 4'd4, r, e);
      checks++;
      if (r !== 8'hF9) begin failures++; $display("[TB] FAIL b2b_second: got %h expected f9", r); end
   endtask

   task automatic test_step();
      logic [7:0] expRes;
      logic       expErr;
      int         expEdges, edges;
      for (int i = 0; i < 13; i++) begin
         if (i == 0) begin
            dataB = 8'h01; modeB = 3'b000; amountB = 4'd7;
         end else begin
            dataB = 8'($urandom); modeB = 3'($urandom_range(0, 5)); amountB = 4'($urandom);
         end
         refModel(dataB, modeB, int'(amountB), 4, expRes, expErr, expEdges);
         startB = 1'b1;
         @(posedge clk); #1;
         startB = 1'b0;
         edges = 0;
         @(negedge clk);
         while (doneB !== 1'b1 && edges < 40) begin
            @(posedge clk); edges++;
            @(negedge clk);
         end
         checks++;
         if (doneB !== 1'b1 || resultB !== expRes || errB !== expErr || edges !== expEdges) begin
            failures++;
            $display("[TB] FAIL step4_op%0d: got done=%b result=%h err=%b lat=%0d expected 1 %h %b %0d",
                     i, doneB, resultB, errB, edges, expRes, expErr, expEdges);
         end
         if (i == 0) begin
            checks++;
            if (resultB !== 8'h80 || edges !== 2) begin
               failures++;
               $display("[TB] FAIL step4_directed: got %h/%0d expected 80/2", resultB, edges);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_lsl();
      test_asr_rotate();
      test_clamp_zero();
      test_illegal();
      test_ignored_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
